alu_mc: RTL

- Parametrised, multi-cycle successor to the single-cycle RV32I execute ALU.
- Executes all base integer ops, branch compares and address adds in one cycle.
- Adds the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as iterative shift-add and restoring-divide engines.
- Sits between decode/regfile read and writeback, with valid/ready handshakes on both sides so the pipeline can stall on long ops.

---
 rtl/alu_mc.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/M execute ALU with valid/ready handshakes on both sides.
// Define ALU_MC_FAST_MUL_EN to complete multiplies in one cycle on a combinational multiplier.
module alu_mc #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            eq,
    output logic            lt,
    output logic            ltu,
    output logic            busy
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned DW  = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    logic [1:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d, busy_q, busy_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [2:0]      op3_q, op3_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

    logic            eq_c, lt_c, ltu_c, taken_c, is_mext_c, accept_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] base_c;
    logic            a_sgn_c, b_sgn_c, dsgn_c, da_neg_c, db_neg_c;
    logic [DW-1:0]   a_ext_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;
    logic [DW-1:0]   shl_c, div_step_c;
    logic [XLEN:0]   trial_c;
    logic [XLEN-1:0] quot_c, rem_c, fin_c;

    assign eq_c      = (a == b);
    assign lt_c      = ($signed(a) < $signed(b));
    assign ltu_c     = (a < b);
    assign shamt_c   = b[SHW-1:0];
    assign is_mext_c = (opcode == OPC_OP) && (func7 == F7_MEXT);
    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept_c  = in_valid && in_ready;

    // Multiply operand extension: MULHU unsigned a, only MUL/MULH treat b as signed
    assign a_sgn_c = (func3[1:0] != 2'b11);
    assign b_sgn_c = !func3[1];
    assign a_ext_c = {{XLEN{a_sgn_c & a[XLEN-1]}}, a};

    // Divide works on magnitudes; signs restored when the result is loaded
    assign dsgn_c   = !func3[0];
    assign da_neg_c = dsgn_c & a[XLEN-1];
    assign db_neg_c = dsgn_c & b[XLEN-1];
    assign a_mag_c  = da_neg_c ? XLEN'(0) - a : a;
    assign b_mag_c  = db_neg_c ? XLEN'(0) - b : b;

    // One restoring step: acc holds {remainder, dividend/quotient}
    assign shl_c      = {acc_q[DW-2:0], 1'b0};
    assign trial_c    = {acc_q[DW-1], shl_c[DW-1:XLEN]} - {1'b0, mcand_q[XLEN-1:0]};
    assign div_step_c = trial_c[XLEN] ? shl_c : {trial_c[XLEN-1:0], shl_c[XLEN-1:1], 1'b1};

    assign quot_c = acc_q[XLEN-1:0];
    assign rem_c  = acc_q[DW-1:XLEN];

    always_comb begin
        fin_c = '0;
        if (!op3_q[2]) begin
            fin_c = (op3_q[1:0] == 2'b00) ? acc_q[XLEN-1:0] : acc_q[DW-1:XLEN];
        end else if (op3_q[1]) begin
            fin_c = rneg_q ? XLEN'(0) - rem_c : rem_c;
        end else if (div0_q) begin
            fin_c = '1;
        end else begin
            fin_c = qneg_q ? XLEN'(0) - quot_c : quot_c;
        end
    end

`ifdef ALU_MC_FAST_MUL_EN
    logic [DW-1:0] b_ext_c, prod_c;
    assign b_ext_c = {{XLEN{b_sgn_c & b[XLEN-1]}}, b};
    assign prod_c  = a_ext_c * b_ext_c;
`else
    // Only b's low XLEN bits are iterated; a negative b is corrected up front
    logic [DW-1:0] mul_init_c;
    assign mul_init_c = (b_sgn_c && b[XLEN-1]) ? DW'(0) - {a, {XLEN{1'b0}}} : '0;
`endif

    // Single-cycle base integer, branch and address results
    always_comb begin
        base_c  = '0;
        taken_c = 1'b0;
        case (func3)
            3'b000:  taken_c = eq_c;
            3'b001:  taken_c = !eq_c;
            3'b100:  taken_c = lt_c;
            3'b101:  taken_c = !lt_c;
            3'b110:  taken_c = ltu_c;
            3'b111:  taken_c = !ltu_c;
            default: taken_c = 1'b0;
        endcase
        case (opcode)
            OPC_LUI:                                 base_c = b;
            OPC_AUIPC, OPC_JALR, OPC_LOAD, OPC_STORE: base_c = a + b;
            OPC_BRANCH:                              base_c = XLEN'(taken_c);
            OPC_OPIMM, OPC_OP: begin
                case (func3)
                    3'b000:  base_c = (opcode == OPC_OP && func7[5]) ? a - b : a + b;
                    3'b001:  base_c = a << shamt_c;
                    3'b010:  base_c = XLEN'(lt_c);
                    3'b011:  base_c = XLEN'(ltu_c);
                    3'b100:  base_c = a ^ b;
                    3'b101:  base_c = func7[5] ? XLEN'($signed(a) >>> shamt_c) : a >> shamt_c;
                    3'b110:  base_c = a | b;
                    default: base_c = a & b;
                endcase
            end
            default: base_c = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        op3_d       = op3_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        div0_d      = div0_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    eq_d  = eq_c;
                    lt_d  = lt_c;
                    ltu_d = ltu_c;
                    op3_d = func3;
                    cnt_d = '0;
                    if (is_mext_c && !func3[2]) begin
`ifdef ALU_MC_FAST_MUL_EN
                        out_valid_d = 1'b1;
                        result_d    = (func3[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[DW-1:XLEN];
`else
                        state_d  = S_MUL;
                        acc_d    = mul_init_c;
                        mcand_d  = a_ext_c;
                        mplier_d = b;
`endif
                    end else if (is_mext_c) begin
                        state_d = S_DIV;
                        acc_d   = {{XLEN{1'b0}}, a_mag_c};
                        mcand_d = {{XLEN{1'b0}}, b_mag_c};
                        qneg_d  = da_neg_c ^ db_neg_c;
                        rneg_d  = da_neg_c;
                        div0_d  = (b == '0);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = base_c;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = {mcand_q[DW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_step_c;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b1;
                result_d    = fin_c;
                state_d     = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            op3_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            op3_q       <= op3_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            div0_q      <= div0_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign ltu       = ltu_q;
    assign busy      = busy_q;

endmodule
